sram_mem_controller: RTL and testbench



---
 rtl/sram_mem_controller.sv | 149 ++++++++++++++
 tb/tb_sram_mem_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_controller.sv
// sram_mem_controller
// Services one 32-bit load/store from the MEM stage at a time. Each request
// becomes two 16-bit SRAM accesses: low half first, then high half. ready is
// held low until the access completes, and the pipeline treats that low level
// as a freeze. address, write_data and the request lines are used live,
// because the frozen pipeline keeps them stable for the whole access.
module sram_mem_controller #(
  parameter logic [31:0] BASE_ADDR    = 32'd1024,
  parameter int          PHASE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter wide enough to hold PHASE_CYCLES-1 even when PHASE_CYCLES is 1.
  localparam int             CW   = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST = CW'(PHASE_CYCLES - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            is_wr;
  logic            req;
  logic            phase_end;
  logic [31:0]     offset;
  logic [16:0]     word;
  logic            drive;
  logic [15:0]     dq_out;
  logic            unused_bits;

  // A request is either a load or a store. A store wins when both are raised.
  assign req       = rd_en | wr_en;
  assign phase_end = (cnt == LAST);

  // SRAM word index. The subtraction wraps, so addresses below BASE_ADDR
  // alias onto the top of the SRAM rather than being rejected.
  assign offset      = address - BASE_ADDR;
  assign word        = offset[18:2];
  assign unused_bits = ^{offset[31:19], offset[1:0]};

  // Next-state and phase counter: IDLE -> LOW -> HIGH -> DONE -> IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end
      end
      LOW: begin
        if (phase_end) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HIGH: begin
        if (phase_end) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // SRAM pin and ready decode from the current state. Addresses go out only
  // while an access is in flight, so the bus idles at address 0.
  always_comb begin
    ready     = 1'b0;
    SRAM_ADDR = 18'd0;
    drive     = 1'b0;
    dq_out    = write_data[15:0];
    case (state)
      IDLE: ready = ~req;
      LOW: begin
        SRAM_ADDR = {word, 1'b0};
        drive     = is_wr;
        dq_out    = write_data[15:0];
      end
      HIGH: begin
        SRAM_ADDR = {word, 1'b1};
        drive     = is_wr;
        dq_out    = write_data[31:16];
      end
      DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign SRAM_WE_N = ~drive;
  assign SRAM_DQ   = drive ? dq_out : 16'hzzzz;

  // State register. The access type is latched when the access starts, so a
  // request line that drops mid-access cannot turn a write into a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      is_wr <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req)
        is_wr <= wr_en;
    end
  end

  // Load data capture on the final cycle of each half, giving the SRAM the
  // whole phase to settle. Stores leave read_data untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= 32'd0;
    end else if (!is_wr && phase_end) begin
      if (state == LOW)
        read_data[15:0]  <= SRAM_DQ;
      else if (state == HIGH)
        read_data[31:16] <= SRAM_DQ;
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller. Two instances share the request inputs:
// u0 uses PHASE_CYCLES=2 and is backed by an array SRAM model. u1 uses
// PHASE_CYCLES=1 and reads from a fixed address-derived pattern. The expected
// per-cycle pin schedule and the reference memory come from the access rules
// of the controller.
module tb_sram_mem_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;

  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1;
  wire  [15:0] dq0, dq1;
  logic [17:0] sa0, sa1;
  logic        we0, we1;

  always #5 clk = ~clk;

  sram_mem_controller #(.BASE_ADDR(32'd1024), .PHASE_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(rdata0), .ready(ready0),
    .SRAM_DQ(dq0), .SRAM_ADDR(sa0), .SRAM_WE_N(we0));

  sram_mem_controller #(.BASE_ADDR(32'd1024), .PHASE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(rdata1), .ready(ready1),
    .SRAM_DQ(dq1), .SRAM_ADDR(sa1), .SRAM_WE_N(we1));

  // Board SRAM for u0. The SRAM drives the bus whenever WE_N is high. It
  // drives stored data during loads and 0 otherwise, so a controller that
  // fails to release the bus shows up as a value other than 0.
  logic [15:0] mem0 [0:262143];
  logic        rd_active, pre_en;
  logic [17:0] pre_addr;
  logic [15:0] pre_data;

  always @(posedge clk) begin
    if (pre_en)    mem0[pre_addr] <= pre_data;
    else if (!we0) mem0[sa0]      <= dq0;
  end

  assign dq0 = we0 ? (rd_active ? mem0[sa0] : 16'h0000) : 16'hzzzz;
  assign dq1 = we1 ? (rd_active ? (16'hC000 ^ sa1[15:0]) : 16'h0000) : 16'hzzzz;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] ref_mem [int];
  logic [31:0] exp_rd [2];
  logic [31:0] wr_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_get(input logic [17:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
  endfunction

  // One full access starting in the next cycle, with every cycle checked.
  task automatic txn(input int sel, input bit wr, input bit rd,
                     input logic [31:0] a, input logic [31:0] d);
    int          p;
    logic [16:0] w;
    logic [31:0] rexp;
    bit          lo, hi;
    p = (sel != 0) ? 1 : 2;
    w = 17'((a - 32'd1024) >> 2);
    if (sel == 0) rexp = {ref_get({w, 1'b1}), ref_get({w, 1'b0})};
    else          rexp = {16'hC000 ^ {w[14:0], 1'b1}, 16'hC000 ^ {w[14:0], 1'b0}};
    @(negedge clk);
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    rd_active = rd && !wr;
    for (int k = 0; k <= 2 * p + 1; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      lo = (k >= 1) && (k <= p);
      hi = (k > p) && (k <= 2 * p);
      chk("ready", (sel != 0) ? ready1 : ready0, 32'(k == 2 * p + 1));
      chk("sram_addr", (sel != 0) ? sa1 : sa0,
          lo ? {w, 1'b0} : (hi ? {w, 1'b1} : 18'd0));
      chk("we_n", (sel != 0) ? we1 : we0, 32'(!(wr && (lo || hi))));
      if (wr)
        chk("dq_write", (sel != 0) ? dq1 : dq0,
            lo ? d[15:0] : (hi ? d[31:16] : 16'h0000));
      if (k == 2 * p + 1)
        chk("read_data", (sel != 0) ? rdata1 : rdata0, wr ? exp_rd[sel] : rexp);
    end
    if (!wr) begin
      exp_rd[sel] = rexp;
    end else if (sel == 0) begin
      ref_mem[int'({w, 1'b0})] = d[15:0];
      ref_mem[int'({w, 1'b1})] = d[31:16];
      wr_q.push_back(a);
    end
  endtask

  // No request for n cycles: bus released, ready high, load data held.
  task automatic idle(input int sel, input int n);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; rd_active = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("idle_ready", (sel != 0) ? ready1 : ready0, 32'd1);
      chk("idle_we_n", (sel != 0) ? we1 : we0, 32'd1);
      chk("idle_addr", (sel != 0) ? sa1 : sa0, 32'd0);
      chk("idle_dq", (sel != 0) ? dq1 : dq0, 32'd0);
      chk("idle_read_data", (sel != 0) ? rdata1 : rdata0, exp_rd[sel]);
    end
  endtask

  task automatic preload(input logic [17:0] a, input logic [15:0] v);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; rd_active = 1'b0;
    pre_en = 1'b1; pre_addr = a; pre_data = v;
    @(negedge clk);
    pre_en = 1'b0;
    ref_mem[int'(a)] = v;
  endtask

  initial begin
    logic [31:0] a, d;
    bit          wr;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
    rd_active = 1'b0; pre_en = 1'b0; pre_addr = 18'd0; pre_data = 16'd0;
    exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready0", ready0, 32'd1);
    chk("rst_ready1", ready1, 32'd1);
    chk("rst_we_n", we0, 32'd1);
    chk("rst_addr", sa0, 32'd0);
    chk("rst_dq", dq0, 32'd0);
    chk("rst_read_data0", rdata0, 32'd0);
    chk("rst_read_data1", rdata1, 32'd0);

    // Store, then load the same word from a preloaded SRAM
    txn(0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
    idle(0, 2);
    preload(18'd2, 16'hBEEF);
    preload(18'd3, 16'hDEAD);
    txn(0, 1'b0, 1'b1, 32'd1028, 32'd0);
    idle(0, 3);

    // Back-to-back store and load with no idle cycle between
    txn(0, 1'b1, 1'b0, 32'd1024, 32'h12345678);
    txn(0, 1'b0, 1'b1, 32'd1024, 32'd0);
    idle(0, 1);

    // Both request lines high means store; idle keeps the bus quiet
    txn(0, 1'b1, 1'b1, 32'd1032, 32'hA5A55A5A);
    idle(0, 4);
    txn(0, 1'b0, 1'b1, 32'd1032, 32'd0);
    idle(0, 1);

    // Reset during the first HIGH cycle of a store
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1024 + 32'h40000;
    write_data = 32'h0BADF00D; rd_active = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_addr", sa0, {17'h10000, 1'b1});
    chk("mid_we_n", we0, 32'd0);
    chk("mid_ready", ready0, 32'd0);
    rst = 1'b1; wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
    chk("post_rst_ready", ready0, 32'd1);
    chk("post_rst_we_n", we0, 32'd1);
    chk("post_rst_dq", dq0, 32'd0);
    chk("post_rst_addr", sa0, 32'd0);
    chk("post_rst_read_data", rdata0, 32'd0);
    txn(0, 1'b0, 1'b1, 32'd1028, 32'd0);
    idle(0, 1);

    // Randomized loads/stores, including wrapped addresses below BASE_ADDR
    for (int i = 0; i < 24; i++) begin
      wr = ($urandom_range(0, 1) == 1);
      d  = $urandom;
      if (wr) begin
        if ($urandom_range(0, 7) == 0)
          a = 32'd1024 - 32'(4 * $urandom_range(1, 4));
        else
          a = 32'd1024 + 32'($urandom_range(0, 255) << 2);
        a = a + 32'($urandom_range(0, 3));
        txn(0, 1'b1, 1'($urandom_range(0, 1)), a, d);
      end else begin
        a = wr_q[$urandom_range(0, wr_q.size() - 1)];
        txn(0, 1'b0, 1'b1, a, d);
      end
      if ($urandom_range(0, 2) != 0) idle(0, $urandom_range(1, 2));
    end
    idle(0, 2);

    // PHASE_CYCLES=1 instance, started from a common reset
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; rd_active = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
    txn(1, 1'b0, 1'b1, 32'd1036, 32'd0);
    idle(1, 2);
    txn(1, 1'b1, 1'b0, 32'd1040, $urandom);
    txn(1, 1'b0, 1'b1, 32'd1016, 32'd0);
    idle(1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
